// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with level flags, error pulses, flush and optional FWFT output
module sync_fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 write_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic                 full_out,
    output logic                 almost_full_out,
    output logic                 wr_err_out,
    input  logic                 read_en_i,
    output logic [WIDTH-1:0]     rdata_out,
    output logic                 rvalid_out,
    output logic                 empty_out,
    output logic                 almost_empty_out,
    output logic                 rd_err_out,
    output logic [PTR_WIDTH:0]   count_out
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 wr_err_q, wr_err_d;
    logic                 rd_err_q, rd_err_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 wr_acc;
    logic                 rd_acc;

    // Status flags come straight from the registered count, so they describe the state after the last edge
    always_comb begin
        full_out         = (count_q == DEPTH_C);
        empty_out        = (count_q == '0);
        almost_full_out  = (count_q >= AFULL_C);
        almost_empty_out = (count_q <= AEMPTY_C);
        count_out        = count_q;
        wr_err_out       = wr_err_q;
        rd_err_out       = rd_err_q;
        wr_acc           = write_en_i & ~full_out & ~flush_i;
        rd_acc           = read_en_i & ~empty_out & ~flush_i;
    end

    // Next pointer/count/error state; flush clears everything and suppresses error pulses
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_err_d = 1'b0;
        rd_err_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            wr_err_d = write_en_i & full_out;
            rd_err_d = read_en_i & empty_out;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array is deliberately not reset; writes in a reset cycle are dropped
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata_out  = mem_q[rd_ptr_q];
            assign rvalid_out = ~empty_out;
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            // Registered read port: data captured on an accepted pop, valid for one cycle
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (flush_i) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
                end
            end

            assign rdata_out  = rdata_q;
            assign rvalid_out = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param in both read modes
module tb_sync_fifo_param;

    localparam int W = 32;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic write_en = 1'b0;
    logic read_en = 1'b0;
    logic [W-1:0] wdata = '0;

    logic f0_full, f0_afull, f0_werr, f0_rvalid, f0_empty, f0_aempty, f0_rerr;
    logic [W-1:0] f0_rdata;
    logic [4:0] f0_count;
    logic f1_full, f1_afull, f1_werr, f1_rvalid, f1_empty, f1_aempty, f1_rerr;
    logic [W-1:0] f1_rdata;
    logic [4:0] f1_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .PTR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .write_en_i(write_en), .wdata_i(wdata),
        .full_out(f0_full), .almost_full_out(f0_afull), .wr_err_out(f0_werr),
        .read_en_i(read_en), .rdata_out(f0_rdata), .rvalid_out(f0_rvalid),
        .empty_out(f0_empty), .almost_empty_out(f0_aempty), .rd_err_out(f0_rerr),
        .count_out(f0_count)
    );

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .PTR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .write_en_i(write_en), .wdata_i(wdata),
        .full_out(f1_full), .almost_full_out(f1_afull), .wr_err_out(f1_werr),
        .read_en_i(read_en), .rdata_out(f1_rdata), .rvalid_out(f1_rvalid),
        .empty_out(f1_empty), .almost_empty_out(f1_aempty), .rd_err_out(f1_rerr),
        .count_out(f1_count)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus the registered side outputs
    logic [W-1:0] q[$];
    logic m_valid = 1'b0;
    logic m_werr = 1'b0;
    logic m_rerr = 1'b0;
    logic m_rv0 = 1'b0;
    logic [W-1:0] m_rd0 = '0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_werr = 1'b0;
            m_rerr = 1'b0;
            m_rv0 = 1'b0;
            m_rd0 = '0;
            m_valid = 1'b1;
        end else if (flush) begin
            q.delete();
            m_werr = 1'b0;
            m_rerr = 1'b0;
            m_rv0 = 1'b0;
        end else begin
            m_werr = write_en && (q.size() == D);
            m_rerr = read_en && (q.size() == 0);
            m_rv0 = 1'b0;
            if (read_en && q.size() > 0) begin
                m_rd0 = q.pop_front();
                m_rv0 = 1'b1;
            end
            if (write_en && !m_werr) q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("count0", W'(f0_count), W'(q.size()));
            chk("full0", W'(f0_full), W'(q.size() == D));
            chk("afull0", W'(f0_afull), W'(q.size() >= 12));
            chk("empty0", W'(f0_empty), W'(q.size() == 0));
            chk("aempty0", W'(f0_aempty), W'(q.size() <= 4));
            chk("werr0", W'(f0_werr), W'(m_werr));
            chk("rerr0", W'(f0_rerr), W'(m_rerr));
            chk("rvalid0", W'(f0_rvalid), W'(m_rv0));
            chk("rdata0", f0_rdata, m_rd0);
            chk("count1", W'(f1_count), W'(q.size()));
            chk("werr1", W'(f1_werr), W'(m_werr));
            chk("rerr1", W'(f1_rerr), W'(m_rerr));
            chk("rvalid1", W'(f1_rvalid), W'(q.size() > 0));
            if (q.size() > 0) chk("rdata1", f1_rdata, q[0]);
        end
    end

    task automatic cyc(input logic we, input logic [W-1:0] wd, input logic re, input logic fl, input logic rs);
        write_en = we;
        wdata = wd;
        read_en = re;
        flush = fl;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_count", W'(f0_count), 0);
        chk("rst_empty", W'(f0_empty), 1);
        chk("rst_aempty", W'(f0_aempty), 1);
        chk("rst_rdata", f0_rdata, 0);
        chk("rst_rvalid1", W'(f1_rvalid), 0);

        for (int i = 1; i <= 16; i++) begin
            cyc(1, W'(i), 0, 0, 0);
            if (i == 11) chk("afull_at11", W'(f0_afull), 0);
            if (i == 12) chk("afull_at12", W'(f0_afull), 1);
        end
        chk("fill_full", W'(f0_full), 1);
        chk("fill_count", W'(f0_count), 16);

        cyc(1, 32'hDEAD, 0, 0, 0);
        chk("ovf_werr", W'(f0_werr), 1);
        chk("ovf_count", W'(f0_count), 16);
        cyc(0, 0, 0, 0, 0);
        chk("ovf_werr_clear", W'(f0_werr), 0);

        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk("drain_rvalid", W'(f0_rvalid), 1);
            chk("drain_rdata", f0_rdata, W'(i + 1));
        end
        chk("drain_empty", W'(f0_empty), 1);

        cyc(0, 0, 1, 0, 0);
        chk("udf_rerr", W'(f0_rerr), 1);
        chk("udf_rvalid", W'(f0_rvalid), 0);
        chk("udf_count", W'(f0_count), 0);

        cyc(1, 32'h100, 1, 0, 0);
        chk("simempty_rerr", W'(f0_rerr), 1);
        chk("simempty_count", W'(f0_count), 1);

        for (int i = 1; i < 16; i++) cyc(1, W'(32'h100 + i), 0, 0, 0);
        chk("refill_count", W'(f0_count), 16);

        cyc(1, 32'hBEEF, 1, 0, 0);
        chk("simfull_werr", W'(f0_werr), 1);
        chk("simfull_rdata", f0_rdata, 32'h100);
        chk("simfull_count", W'(f0_count), 15);

        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
        chk("to8_count", W'(f0_count), 8);
        for (int i = 0; i < 40; i++) begin
            cyc(1, W'(32'h200 + i), 1, 0, 0);
            chk("wrap_count", W'(f0_count), 8);
        end

        cyc(1, 32'h300, 0, 0, 0);
        chk("preflush_count", W'(f0_count), 9);
        cyc(1, 32'h301, 1, 1, 0);
        chk("flush_count", W'(f0_count), 0);
        chk("flush_empty", W'(f0_empty), 1);
        chk("flush_werr", W'(f0_werr), 0);
        chk("flush_rerr", W'(f0_rerr), 0);

        cyc(1, 32'hA5, 0, 0, 0);
        chk("fwft_rdata", f1_rdata, 32'hA5);
        chk("fwft_rvalid", W'(f1_rvalid), 1);
        cyc(0, 0, 1, 0, 0);
        chk("fwft_pop_rvalid", W'(f1_rvalid), 0);
        chk("reg_pop_rdata", f0_rdata, 32'hA5);

        for (int i = 0; i < 3; i++) cyc(1, W'(32'h400 + i), 0, 0, 0);
        cyc(1, 32'h55, 0, 0, 1);
        chk("midrst_count", W'(f0_count), 0);
        chk("midrst_rdata", f0_rdata, 0);
        cyc(0, 0, 0, 0, 0);
        chk("midrst_after_count", W'(f0_count), 0);
        chk("midrst_after_werr", W'(f0_werr), 0);
        cyc(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
